btn_event_reader: RTL and testbench

- Reads the badge's eight active-low push buttons (nbtn), synchronises and debounces them, and presents a debounced level vector.
- Emits a queued press/release event stream over a valid/ready handshake.
- It is the input-side counterpart to the LED output drivers. Top-level logic pops events to drive LED patterns instead of free-running.

---
 rtl/btn_event_pkg.sv | 23 ++
 rtl/btn_evt_fifo.sv | 73 +++++++
 rtl/btn_event_reader.sv | 144 ++++++++++++++
 tb/tb_btn_event_reader.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/btn_event_pkg.sv
// Shared event encoding for the button event reader.
package btn_event_pkg;

  localparam int unsigned EVT_W = 4;
  localparam int unsigned IDX_W = 3;

  localparam logic EVT_PRESS   = 1'b1;
  localparam logic EVT_RELEASE = 1'b0;

  // Event payload: polarity in the MSB, button index below.
  typedef struct packed {
    logic             pol;
    logic [IDX_W-1:0] idx;
  } evt_t;

  function automatic logic [EVT_W-1:0] make_evt(input logic pol, input logic [IDX_W-1:0] idx);
    evt_t e;
    e.pol = pol;
    e.idx = idx;
    return e;
  endfunction

endpackage

// File: rtl/btn_evt_fifo.sv
// First-word fall-through event queue with registered head and drop-on-full.
module btn_evt_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic         o_valid,
  output logic [W-1:0] o_dout,
  output logic         o_drop_c
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_valid;
  logic [W-1:0]  r_dout;

  logic          w_full;
  logic          w_pop;
  logic          w_do_push;
  logic [CW-1:0] w_count_nxt;
  logic [AW-1:0] w_rd_nxt;

  // Handshake qualification; a full queue still accepts when it pops the same cycle.
  always_comb begin
    w_full      = (r_count == CW'(DEPTH));
    w_pop       = i_pop & r_valid;
    w_do_push   = i_push & (~w_full | w_pop);
    o_drop_c    = i_push & w_full & ~w_pop;
    w_count_nxt = r_count + CW'(w_do_push) - CW'(w_pop);
    w_rd_nxt    = w_pop ? (r_rd_ptr + AW'(1)) : r_rd_ptr;
  end

  // Storage array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // Pointers, occupancy and the registered head word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_dout   <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      r_rd_ptr <= w_rd_nxt;
      r_count  <= w_count_nxt;
      r_valid  <= (w_count_nxt != '0);
      if (w_count_nxt != '0) begin
        r_dout <= (w_do_push && (r_wr_ptr == w_rd_nxt)) ? i_din : r_mem[w_rd_nxt];
      end
    end
  end

  assign o_valid = r_valid;
  assign o_dout  = r_dout;

endmodule

// File: rtl/btn_event_reader.sv
// Synchronises and debounces active-low buttons and queues press/release events.
module btn_event_reader
  import btn_event_pkg::*;
#(
  parameter int unsigned NUM_BTN        = 8,
  parameter int unsigned TICK_DIV       = 8000,
  parameter int unsigned DEBOUNCE_TICKS = 10,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] nbtn,
  output logic [NUM_BTN-1:0] btn_state,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [EVT_W-1:0]   evt_code,
  output logic               evt_overflow,
  input  logic               ovf_clr
);

  localparam int unsigned TW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CNT_W = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;

  logic [NUM_BTN-1:0] r_sync1;
  logic [NUM_BTN-1:0] r_sync2;
  logic [TW-1:0]      r_tick_cnt;
  logic [CNT_W-1:0]   r_cnt [NUM_BTN];
  logic [NUM_BTN-1:0] r_state;
  logic [NUM_BTN-1:0] r_pending;
  logic [NUM_BTN-1:0] r_pol;
  logic               r_ovf;

  logic [NUM_BTN-1:0] w_raw;
  logic               w_tick;
  logic [NUM_BTN-1:0] w_flip;
  logic [NUM_BTN-1:0] w_sel_oh;
  logic [IDX_W-1:0]   w_sel_idx;
  logic               w_sel_pol;
  logic               w_sel_any;
  logic [EVT_W-1:0]   w_evt;
  logic               w_drop;

  // Two-flop synchroniser; idles at released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= nbtn;
      r_sync2 <= r_sync1;
    end
  end

  assign w_raw = ~r_sync2;

  // Free-running sample tick divider.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
    end else if (r_tick_cnt == TW'(TICK_DIV - 1)) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TW'(1);
    end
  end

  assign w_tick = (r_tick_cnt == TW'(TICK_DIV - 1));

  // A button flips once it has disagreed for the full debounce window.
  always_comb begin
    w_flip = '0;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      w_flip[i] = w_tick && (w_raw[i] != r_state[i]) &&
                  (r_cnt[i] == CNT_W'(DEBOUNCE_TICKS - 1));
    end
  end

  // Per-button debounce counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_BTN; i++) r_cnt[i] <= '0;
    end else if (w_tick) begin
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        if ((w_raw[i] == r_state[i]) || w_flip[i]) r_cnt[i] <= '0;
        else                                         r_cnt[i] <= r_cnt[i] + CNT_W'(1);
      end
    end
  end

  // Debounced level, pending-event flags and the polarity captured at the flip.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= '0;
      r_pending <= '0;
      r_pol     <= '0;
    end else begin
      r_state   <= r_state ^ w_flip;
      r_pending <= (r_pending & ~w_sel_oh) | w_flip;
      r_pol     <= (r_pol & ~w_flip) | (~r_state & w_flip);
    end
  end

  // Lowest-index pending button wins the push slot this cycle.
  always_comb begin
    w_sel_any = 1'b0;
    w_sel_idx = '0;
    w_sel_pol = EVT_RELEASE;
    w_sel_oh  = '0;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      if (r_pending[i] && !w_sel_any) begin
        w_sel_any   = 1'b1;
        w_sel_idx   = IDX_W'(i);
        w_sel_pol   = r_pol[i];
        w_sel_oh[i] = 1'b1;
      end
    end
    w_evt = make_evt(w_sel_pol, w_sel_idx);
  end

  btn_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EVT_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_push   (w_sel_any),
    .i_din    (w_evt),
    .i_pop    (evt_ready),
    .o_valid  (evt_valid),
    .o_dout   (evt_code),
    .o_drop_c (w_drop)
  );

  // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_ovf <= 1'b0;
    else if (w_drop)  r_ovf <= 1'b1;
    else if (ovf_clr) r_ovf <= 1'b0;
  end

  assign btn_state    = r_state;
  assign evt_overflow = r_ovf;

endmodule

// File: tb/tb_btn_event_reader.sv
// Directed bench for btn_event_reader with a short tick and debounce window.
module tb_btn_event_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] nbtn;
  logic [7:0] btn_state;
  logic       evt_valid;
  logic       evt_ready;
  logic [3:0] evt_code;
  logic       evt_overflow;
  logic       ovf_clr;

  int n_checks = 0;
  int n_errors = 0;

  btn_event_reader #(
    .NUM_BTN        (8),
    .TICK_DIV       (4),
    .DEBOUNCE_TICKS (3),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .nbtn         (nbtn),
    .btn_state    (btn_state),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_code     (evt_code),
    .evt_overflow (evt_overflow),
    .ovf_clr      (ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  nbtn;
    logic [2:0]  n;
    logic [15:0] codes;   // first event in the low nibble
    logic [7:0]  state;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Pops n events one at a time, checking each head, then expects an empty queue.
  task automatic drain(input string name, input int n, input logic [15:0] codes);
    logic [15:0] c;
    c = codes;
    for (int k = 0; k < n; k++) begin
      check({name, " valid"}, 32'(evt_valid), 32'd1);
      check({name, " code"}, 32'(evt_code), 32'(c[k*4 +: 4]));
      evt_ready = 1'b1;
      step();
      evt_ready = 1'b0;
    end
    check({name, " empty"}, 32'(evt_valid), 32'd0);
  endtask

  initial begin
    int lat;
    int bad;

    vecs[0] = '{nbtn: 8'hFB, n: 3'd1, codes: 16'h000A, state: 8'h04};
    vecs[1] = '{nbtn: 8'hFF, n: 3'd1, codes: 16'h0002, state: 8'h00};
    vecs[2] = '{nbtn: 8'hDD, n: 3'd2, codes: 16'h00D9, state: 8'h22};
    vecs[3] = '{nbtn: 8'hFF, n: 3'd2, codes: 16'h0051, state: 8'h00};
    vecs[4] = '{nbtn: 8'hF8, n: 3'd3, codes: 16'h0A98, state: 8'h07};
    vecs[5] = '{nbtn: 8'hFF, n: 3'd3, codes: 16'h0210, state: 8'h00};

    rst_n     = 1'b1;
    nbtn      = 8'hFF;
    evt_ready = 1'b0;
    ovf_clr   = 1'b0;
    #1 rst_n  = 1'b0;
    #1;
    check("rst btn_state", 32'(btn_state), 32'h0);
    check("rst evt_valid", 32'(evt_valid), 32'h0);
    check("rst evt_code", 32'(evt_code), 32'h0);
    check("rst evt_overflow", 32'(evt_overflow), 32'h0);
    wait_cycles(3);
    rst_n = 1'b1;

    // Idle with all buttons released.
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (btn_state != 8'h0 || evt_valid || evt_overflow) bad++;
    end
    check("idle quiet", 32'(bad), 32'd0);

    // Press latency and single-event path with the consumer always ready.
    evt_ready = 1'b1;
    nbtn = 8'hFB;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (btn_state[2]) begin
        lat = i;
        break;
      end
    end
    check("latency >= 11", 32'(lat >= 11), 32'd1);
    check("latency <= 14", 32'(lat <= 14), 32'd1);
    check("push cycle no valid", 32'(evt_valid), 32'd0);
    step();
    check("press valid", 32'(evt_valid), 32'd1);
    check("press code", 32'(evt_code), 32'hA);
    step();
    check("popped", 32'(evt_valid), 32'd0);
    check("code held", 32'(evt_code), 32'hA);
    nbtn = 8'hFF;
    wait_cycles(40);
    check("released", 32'(btn_state), 32'h0);
    check("release consumed", 32'(evt_valid), 32'd0);
    evt_ready = 1'b0;

    // Short glitch must not flip the debounced level.
    nbtn = 8'hFB;
    wait_cycles(5);
    nbtn = 8'hFF;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (btn_state != 8'h0 || evt_valid) bad++;
    end
    check("glitch rejected", 32'(bad), 32'd0);

    // Table of level changes applied with the consumer stalled, then drained.
    for (int v = 0; v < 6; v++) begin
      nbtn = vecs[v].nbtn;
      bad = 0;
      for (int i = 0; i < 40; i++) begin
        step();
        if (btn_state != 8'h0 && btn_state != vecs[v].state &&
            btn_state != ~vecs[v].nbtn && (btn_state & ~vecs[v].state) != 8'h0 &&
            vecs[v].state != 8'h0) bad++;
      end
      check($sformatf("vec%0d btn_state", v), 32'(btn_state), 32'(vecs[v].state));
      check($sformatf("vec%0d overflow", v), 32'(evt_overflow), 32'd0);
      drain($sformatf("vec%0d drain", v), int'(vecs[v].n), vecs[v].codes);
    end

    // Simultaneous flips land on the same cycle.
    nbtn = 8'hDD;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (btn_state != 8'h0) begin
        lat = i;
        break;
      end
    end
    check("same-tick flip", 32'(btn_state), 32'h22);
    check("same-tick seen", 32'(lat != 0), 32'd1);
    wait_cycles(10);
    drain("same-tick drain", 2, 16'h00D9);
    nbtn = 8'hFF;
    wait_cycles(40);
    drain("same-tick release", 2, 16'h0051);

    // Five events into a four-deep queue: last one dropped.
    nbtn = 8'hF8;
    wait_cycles(40);
    nbtn = 8'hFB;
    wait_cycles(40);
    check("ovf btn_state", 32'(btn_state), 32'h04);
    check("ovf set", 32'(evt_overflow), 32'd1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("ovf cleared", 32'(evt_overflow), 32'd0);
    drain("ovf drain", 4, 16'h0A98);
    nbtn = 8'hFF;
    wait_cycles(40);
    drain("ovf tail", 1, 16'h0002);

    // Reset with events queued and a debounce in flight.
    nbtn = 8'hF8;
    wait_cycles(40);
    check("pre-reset valid", 32'(evt_valid), 32'd1);
    nbtn = 8'hF9;
    wait_cycles(6);
    rst_n = 1'b0;
    nbtn  = 8'hFF;
    #1;
    check("mid-reset valid", 32'(evt_valid), 32'd0);
    check("mid-reset btn_state", 32'(btn_state), 32'h0);
    step();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (evt_valid || btn_state != 8'h0 || evt_overflow) bad++;
    end
    check("no stale event", 32'(bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
